alu_issue_ctrl: RTL

//  Upstream issue stage for ALU593: buffers instruction words {op,A,B,tag} in a FIFO and issues them one at a time.

---
 rtl/tinyalu_pkg.sv | 45 ++++
 rtl/alu_issue_ctrl_fifo.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared ALU opcode encoding plus the types used by the
// alu_issue_ctrl issue stage (instruction word, issue FSM states, NOP check).
package tinyalu_pkg;

  typedef enum logic [3:0] {
    op_nop   = 4'h0,
    op_add   = 4'h1,
    op_and   = 4'h2,
    op_xor   = 4'h3,
    op_mul   = 4'h4,
    op_sub   = 4'h5,
    op_load  = 4'h6,
    op_store = 4'h7,
    op_or    = 4'h8,
    op_shl   = 4'h9,
    op_shr   = 4'hA,
    op_not   = 4'hB,
    op_res1  = 4'hC,
    op_res2  = 4'hD,
    op_res3  = 4'hE,
    op_nop1  = 4'hF
  } alu_opcode_t;

  // Tag field is sized for the widest caller tag; narrower tags are zero-extended.
  localparam int unsigned ALU_TAG_W_MAX = 16;

  typedef struct packed {
    alu_opcode_t              op;
    logic [7:0]               a;
    logic [7:0]               b;
    logic [ALU_TAG_W_MAX-1:0] tag;
  } alu_instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    NOP,
    RESP
  } issue_state_t;

  function automatic logic is_nop_op(input alu_opcode_t op);
    return (op == op_nop) || (op == op_nop1);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// alu_instr_fifo: synchronous show-ahead FIFO of alu_instr_t words.
// Head entry is visible on data_o whenever empty_o is low.
module alu_instr_fifo
  import tinyalu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  alu_instr_t             data_i,
  input  logic                   pop_i,
  output alu_instr_t             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  alu_instr_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers {op,A,B,tag} instructions, issues them one at a
// time over the ALU start/done handshake and returns each result on a
// valid/ready response port. Counts responses flagged with an ALU error.
// Optional done watchdog: define ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl
  import tinyalu_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result,
  input  logic                   alu_error,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_result,
  output logic                   rsp_error,
  output logic                   rsp_timeout,
  output logic [3:0]             rsp_op,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  issue_state_t     state_q;
  logic [7:0]       alu_a_q;
  logic [7:0]       alu_b_q;
  alu_opcode_t      alu_op_q;
  logic             alu_start_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_result_q;
  logic             rsp_error_q;
  alu_opcode_t      rsp_op_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [7:0]       err_cnt_q;

  alu_instr_t       push_word;
  alu_instr_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             unused_head_tag;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign push_word = '{op: alu_opcode_t'(in_op), a: in_a, b: in_b,
                       tag: ALU_TAG_W_MAX'(in_tag)};
  assign unused_head_tag = ^head.tag;

  alu_instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .data_i  (push_word),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] timer_q;
  logic             rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign rsp_timeout = 1'b0;
`endif

  // Issue FSM: pop in IDLE, hold start through ISSUE/NOP, hold response in RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= op_nop;
      alu_start_q  <= 1'b0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_op_q     <= op_nop;
      rsp_tag_q    <= '0;
      err_cnt_q    <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      timer_q       <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            alu_a_q     <= head.a;
            alu_b_q     <= head.b;
            alu_op_q    <= head.op;
            tag_q       <= head.tag[TAG_W-1:0];
            alu_start_q <= 1'b1;
            state_q     <= is_nop_op(head.op) ? NOP : ISSUE;
`ifdef ALU_ISSUE_TIMEOUT_EN
            timer_q     <= '0;
`endif
          end
        end
        ISSUE: begin
          if (alu_done) begin
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_error_q  <= alu_error;
            rsp_op_q     <= alu_op_q;
            rsp_tag_q    <= tag_q;
            state_q      <= RESP;
`ifdef ALU_ISSUE_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            alu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_op_q      <= alu_op_q;
            rsp_tag_q     <= tag_q;
            state_q       <= RESP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
`endif
          end
        end
        NOP: begin
          alu_start_q <= 1'b0;
          state_q     <= IDLE;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_error_q && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_tag    = rsp_tag_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule
